sine_phase_sched: RTL
=====================

SINE_PHASE_SCHED -- requirements
Module: sine_phase_sched

Interface
REQ-001 SHALL have parameter NR_CHANNELS, default 2, number of sine channels scheduled.
REQ-002 SHALL have parameter RADIAN_WIDTH, default 28, angle width; format S2.(RADIAN_WIDTH-3).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_tick  input  1  sample-rate strobe, one cycle per output sample.
REQ-006 SHALL have port cfg_d  input  RADIAN_WIDTH  configuration data.
REQ-007 SHALL have port cfg_sel  input  2  00 = increment, 01 = sweep step, 10 = control (bit0 enable, bit1 phase-zero request).
REQ-008 SHALL have port cfg_ch  input  CHANNEL_WIDTH  target channel; CHANNEL_WIDTH = clog2(NR_CHANNELS).
REQ-009 SHALL have port cfg_dv  input  1  configuration write strobe; always accepted.
REQ-010 SHALL have ports m_sine_d (RADIAN_WIDTH), m_sine_zero (1), m_sine_ch (CHANNEL_WIDTH), m_sine_dv (1)  output; m_sine_dr (1)  input; these feed the sine generator angle input.
REQ-011 SHALL have port m_overrun  output  1  one-cycle pulse on a dropped tick.

Function
REQ-012 SHALL hold per-channel registers inc[ch] and sweep[ch] (signed RADIAN_WIDTH), en[ch], and zpend[ch].
REQ-013 A cfg write SHALL update the selected register one cycle after the cfg_dv cycle.
REQ-014 A write with cfg_sel 10 SHALL set en[ch] = cfg_d[0]; cfg_d[1] = 1 SHALL set zpend[ch].
REQ-015 A write with cfg_sel 11, or with cfg_ch >= NR_CHANNELS, SHALL be ignored.
REQ-016 The FSM SHALL have states IDLE, SCAN and WAIT.
REQ-017 IDLE: an s_tick sampled high SHALL set ch = 0 and move to SCAN.
REQ-018 SCAN, en[ch] = 0: SHALL advance ch, costing one cycle per disabled channel.
REQ-019 SCAN, en[ch] = 1: SHALL register m_sine_d = inc[ch], m_sine_zero = zpend[ch], m_sine_ch = ch, m_sine_dv = 1, then move to WAIT.
REQ-020 From SCAN, the last channel with no transfer SHALL return the FSM to IDLE.
REQ-021 Latency: tick in cycle T with en[0] = 1 SHALL give m_sine_dv high from cycle T+2.
REQ-022 WAIT: outputs SHALL stay stable until a transfer, i.e. m_sine_dv && m_sine_dr at a rising edge.
REQ-023 On transfer, m_sine_dv SHALL drop and zpend[ch] SHALL clear.
REQ-024 On transfer, inc[ch] SHALL become sat(inc[ch] + sweep[ch]) and ch SHALL advance; after the last channel the FSM SHALL return to IDLE, otherwise to SCAN.
REQ-025 sat() SHALL compute in RADIAN_WIDTH+1 bits and clamp to [-PI, +PI].
REQ-026 PI SHALL equal 2 x trunc(2^(RADIAN_WIDTH-3) x pi/2).
REQ-027 An s_tick sampled outside IDLE SHALL be dropped and SHALL pulse m_overrun the next cycle.
REQ-028 A cfg write to inc[ch] in the same cycle as that channel's sweep update SHALL win; the sweep sum is discarded.
REQ-029 A phase-zero request arriving in the same cycle as that channel's zpend clear SHALL remain set for the next tick.
REQ-030 A cfg write to the channel currently in WAIT SHALL NOT alter the presented m_sine_d or m_sine_zero.
REQ-031 If all channels are disabled, a tick SHALL produce no transfer and SHALL return to IDLE after NR_CHANNELS SCAN cycles.

Reset
REQ-032 While rst_n = 0 at an edge, the block SHALL enter IDLE with ch = 0 and all outputs 0: m_sine_dv, m_sine_zero, m_sine_d, m_sine_ch, m_overrun.
REQ-033 While rst_n = 0 at an edge, en[], zpend[], inc[] and sweep[] SHALL all be 0.
REQ-034 Reset during WAIT SHALL drop m_sine_dv in the next cycle, with no transfer counted.

Structure
REQ-035 The clog2 function, the PI and PI_OVER_2 constant derivations and the angle format width rules SHALL live in a shared package, also used by the sine generator.
REQ-036 Saturating addition SHALL be one sub-module, sat_add_pi, parameterised by width; the FSM and register file stay in sine_phase_sched.

Verification (RADIAN_WIDTH = 28, NR_CHANNELS = 2, PI = 105414356)
REQ-037 Set inc[0] = 1000 and en[0] = 1, m_sine_dr = 1, tick at cycle T -> m_sine_dv high in T+2 only, m_sine_d = 1000, m_sine_ch = 0, m_sine_zero = 0.
REQ-038 Set inc[1] = 105414000, sweep[1] = 1000, en[1] = 1, two ticks -> m_sine_d = 105414000, then 105414356 (clamped); negative mirror gives -105414356.
REQ-039 Request phase-zero on ch0 -> next transfer has m_sine_zero = 1, the following transfer has 0.
REQ-040 Hold m_sine_dr = 0 for 10 cycles after dv -> outputs stable; a second tick during the hold -> m_overrun pulses once and there is no extra transfer.
REQ-041 Both channels enabled, cfg write to inc[0] in the transfer cycle of ch0 -> the written value persists and ch1 is issued next.
REQ-042 Assert rst_n = 0 during WAIT -> m_sine_dv = 0 in the next cycle, all en = 0, and a subsequent tick gives no transfer.

Source files
------------

// File: rtl/sine_phase_sched_pkg.sv
// Shared angle-format package for the sine phase scheduler and sine generator.
// Angles are signed fixed point S2.(W-3): a sign bit, two integer bits, and
// W-3 fraction bits. Provides clog2, PI/2 and PI derivations for a given
// angle width, the scheduler state type and the cfg_sel codes.
package sine_phase_sched_pkg;

  localparam int ANGLE_INT_BITS = 2;

  localparam logic [1:0] CFG_SEL_INC   = 2'b00;
  localparam logic [1:0] CFG_SEL_SWEEP = 2'b01;
  localparam logic [1:0] CFG_SEL_CTRL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2
  } sched_state_t;

  // At least one bit, so a single-channel build still has a legal index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int angle_frac_bits(input int w);
    return w - ANGLE_INT_BITS - 1;
  endfunction

  // trunc(2^frac * pi/2); evaluated at elaboration only.
  function automatic longint pi_over_2(input int w);
    return longint'($floor((2.0 ** real'(angle_frac_bits(w))) * 1.5707963267948966));
  endfunction

  // PI is defined as twice the truncated PI/2 so both stay exactly related.
  function automatic longint pi_val(input int w);
    return 2 * pi_over_2(w);
  endfunction

endpackage

// File: rtl/sine_phase_sched_if.sv
// Angle handshake between the phase scheduler (master) and the sine
// generator (slave).
//   d    : angle, S2.(RADIAN_WIDTH-3)
//   zero : phase-zero request accompanying this angle
//   ch   : channel the angle belongs to
//   dv   : data valid (master)
//   dr   : data ready (slave)
interface sine_phase_sched_if #(
  parameter int RADIAN_WIDTH  = 28,
  parameter int CHANNEL_WIDTH = 1
);
  logic signed [RADIAN_WIDTH-1:0]  d;
  logic                            zero;
  logic        [CHANNEL_WIDTH-1:0] ch;
  logic                            dv;
  logic                            dr;

  modport master (output d, zero, ch, dv, input dr);
  modport slave  (input d, zero, ch, dv, output dr);
endinterface

// File: rtl/sine_phase_sched_sat_add_pi.sv
// sat_add_pi: signed angle addition clamped to [-PI, +PI].
//   a, b : signed WIDTH-bit angles
//   y    : sat(a + b), sum formed in WIDTH+1 bits so it cannot wrap
module sat_add_pi
  import sine_phase_sched_pkg::*;
#(
  parameter int WIDTH = 28
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);

  localparam longint              PI_L     = pi_val(WIDTH);
  localparam logic signed [WIDTH:0] PI_P     = (WIDTH + 1)'(PI_L);
  localparam logic signed [WIDTH:0] NEG_PI_P = -PI_P;

  logic signed [WIDTH:0] sum;

  always_comb begin
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (sum > PI_P) begin
      y = PI_P[WIDTH-1:0];
    end else if (sum < NEG_PI_P) begin
      y = NEG_PI_P[WIDTH-1:0];
    end else begin
      y = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sine_phase_sched.sv
// sine_phase_sched: per-sample scheduler that walks all channels on each
// s_tick and hands every enabled channel's phase increment to the sine
// generator, then advances that increment by its sweep step.
//   clk, rst_n        : clock, synchronous active-low reset
//   s_tick            : one-cycle strobe per output sample
//   cfg_d/sel/ch/dv   : register writes (00 inc, 01 sweep, 10 ctrl)
//   m_sine            : angle handshake towards the sine generator
//   m_overrun         : one-cycle pulse when a tick arrives while busy
//
// state   | meaning
// IDLE    | waiting for s_tick
// SCAN    | looking at channel ch; skip if disabled, else present it
// WAIT    | angle for ch presented, waiting for dv && dr
module sine_phase_sched
  import sine_phase_sched_pkg::*;
#(
  parameter  int NR_CHANNELS   = 2,
  parameter  int RADIAN_WIDTH  = 28,
  localparam int CHANNEL_WIDTH = clog2(NR_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_tick,
  input  logic [RADIAN_WIDTH-1:0]  cfg_d,
  input  logic [1:0]               cfg_sel,
  input  logic [CHANNEL_WIDTH-1:0] cfg_ch,
  input  logic                     cfg_dv,
  sine_phase_sched_if.master       m_sine,
  output logic                     m_overrun
);

  localparam logic [CHANNEL_WIDTH-1:0] LAST_CH = CHANNEL_WIDTH'(NR_CHANNELS - 1);

  sched_state_t                    state;
  logic [CHANNEL_WIDTH-1:0]        ch;
  logic signed [RADIAN_WIDTH-1:0]  inc   [NR_CHANNELS];
  logic signed [RADIAN_WIDTH-1:0]  sweep [NR_CHANNELS];
  logic [NR_CHANNELS-1:0]          en;
  logic [NR_CHANNELS-1:0]          zpend;
  logic signed [RADIAN_WIDTH-1:0]  inc_next;
  logic                            cfg_hit;

  assign cfg_hit = cfg_dv && (32'(cfg_ch) < NR_CHANNELS);

  sat_add_pi #(.WIDTH(RADIAN_WIDTH)) u_sat (
    .a (inc[ch]),
    .b (sweep[ch]),
    .y (inc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ch          <= '0;
      m_sine.d    <= '0;
      m_sine.zero <= 1'b0;
      m_sine.ch   <= '0;
      m_sine.dv   <= 1'b0;
      m_overrun   <= 1'b0;
      en          <= '0;
      zpend       <= '0;
      for (int i = 0; i < NR_CHANNELS; i++) begin
        inc[i]   <= '0;
        sweep[i] <= '0;
      end
    end else begin
      m_overrun <= s_tick && (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (s_tick) begin
            ch    <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (en[ch]) begin
            m_sine.d    <= inc[ch];
            m_sine.zero <= zpend[ch];
            m_sine.ch   <= ch;
            m_sine.dv   <= 1'b1;
            state       <= ST_WAIT;
          end else if (ch == LAST_CH) begin
            state <= ST_IDLE;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        ST_WAIT: begin
          if (m_sine.dv && m_sine.dr) begin
            m_sine.dv <= 1'b0;
            zpend[ch] <= 1'b0;
            inc[ch]   <= inc_next;
            if (ch == LAST_CH) begin
              state <= ST_IDLE;
            end else begin
              ch    <= ch + 1'b1;
              state <= ST_SCAN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the FSM so a same-cycle cfg write overrides the sweep
      // update of inc and re-sets a zpend the transfer just cleared.
      if (cfg_hit) begin
        case (cfg_sel)
          CFG_SEL_INC:   inc[cfg_ch]   <= cfg_d;
          CFG_SEL_SWEEP: sweep[cfg_ch] <= cfg_d;
          CFG_SEL_CTRL: begin
            en[cfg_ch] <= cfg_d[0];
            if (cfg_d[1]) zpend[cfg_ch] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
